// File: rtl/ddr3_rd_arbiter.sv
// ddr3_rd_arbiter: shares the DDR3 Avalon-MM read port between two requesters, tracks
// outstanding bursts in an in-order tag FIFO and steers returned beats. Optional stats: DDR3_RD_ARB_STATS_EN.
module ddr3_rd_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned STARVE_LIMIT    = 64,
    parameter int unsigned MAX_BURST       = 4
) (
    input  logic         ddr3_clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [25:0]  req0_addr,
    input  logic [2:0]   req0_size,
    output logic         req0_ack,
    output logic         rsp0_valid,
    output logic [127:0] rsp0_data,
    input  logic         req1_valid,
    input  logic [25:0]  req1_addr,
    input  logic [2:0]   req1_size,
    output logic         req1_ack,
    output logic         rsp1_valid,
    output logic [127:0] rsp1_data,
    input  logic         ddr3_avl_ready,
    output logic         ddr3_avl_burstbegin,
    output logic [2:0]   ddr3_avl_size,
    output logic         ddr3_avl_read_req,
    output logic [25:0]  ddr3_avl_addr,
    input  logic         ddr3_avl_read_data_valid,
    input  logic [127:0] ddr3_avl_read_data,
    output logic [4:0]   outstanding,
    output logic [1:0]   err_flags,
    output logic [31:0]  stats
);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = 5;
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             cmd_id_q, cmd_id_d;
    logic [25:0]      cmd_addr_q, cmd_addr_d;
    logic [2:0]       cmd_size_q, cmd_size_d;
    logic             bb_q, bb_d;
    logic             size_err_c;
    logic [SW-1:0]    starve_q, starve_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       fifo_q [MAX_OUTSTANDING];
    logic [2:0]       beat_q;
    logic             rsp0_valid_q, rsp1_valid_q;
    logic [127:0]     rsp0_data_q, rsp1_data_q;
    logic [1:0]       err_q;

    logic             can_grant, pick1, accept, gnt1;
    logic             head_id, beat_hit, orphan, pop;
    logic [2:0]       head_size, raw_size;

    // Arbitration: requester 0 wins unless requester 1 has waited STARVE_LIMIT cycles
    assign accept    = (state_q == S_ISSUE) && ddr3_avl_ready;
    assign can_grant = (req0_valid || req1_valid) && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign pick1     = req1_valid && (!req0_valid || (starve_q == SW'(STARVE_LIMIT)));
    assign raw_size  = pick1 ? req1_size : req0_size;
    assign gnt1      = ((state_q == S_IDLE) && can_grant && pick1) ||
                       ((state_q == S_ISSUE) && cmd_id_q);

    // Return path: beats belong to the FIFO head; its size tells when it is complete
    assign {head_id, head_size} = fifo_q[rd_ptr_q];
    assign beat_hit  = ddr3_avl_read_data_valid && (cnt_q != '0);
    assign orphan    = ddr3_avl_read_data_valid && (cnt_q == '0);
    assign pop       = beat_hit && (3'(beat_q + 3'd1) == head_size);

    always_comb begin
        state_d    = state_q;
        cmd_id_d   = cmd_id_q;
        cmd_addr_d = cmd_addr_q;
        cmd_size_d = cmd_size_q;
        bb_d       = 1'b0;
        size_err_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    state_d    = S_ISSUE;
                    cmd_id_d   = pick1;
                    cmd_addr_d = pick1 ? req1_addr : req0_addr;
                    bb_d       = 1'b1;
                    if ((raw_size == 3'd0) || (raw_size > 3'(MAX_BURST))) begin
                        cmd_size_d = 3'd1;
                        size_err_c = 1'b1;
                    end else begin
                        cmd_size_d = raw_size;
                    end
                end
            end
            S_ISSUE: begin
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!req1_valid || req1_ack) begin
            starve_d = '0;
        end else if (!gnt1 && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = SW'(starve_q + SW'(1));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge ddr3_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_id_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_size_q   <= '0;
            bb_q         <= 1'b0;
            starve_q     <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            beat_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            err_q        <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cmd_id_q   <= cmd_id_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_size_q <= cmd_size_d;
            bb_q       <= bb_d;
            starve_q   <= starve_d;
            cnt_q      <= cnt_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= {cmd_id_q, cmd_size_q};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                beat_q   <= '0;
            end else if (beat_hit) begin
                beat_q <= beat_q + 3'd1;
            end
            rsp0_valid_q <= beat_hit && !head_id;
            rsp1_valid_q <= beat_hit && head_id;
            if (beat_hit && !head_id) rsp0_data_q <= ddr3_avl_read_data;
            if (beat_hit && head_id)  rsp1_data_q <= ddr3_avl_read_data;
            err_q <= err_q | {size_err_c, orphan};
        end
    end

    assign req0_ack            = accept && !cmd_id_q;
    assign req1_ack            = accept && cmd_id_q;
    assign ddr3_avl_read_req   = (state_q == S_ISSUE);
    assign ddr3_avl_burstbegin = bb_q;
    assign ddr3_avl_addr       = cmd_addr_q;
    assign ddr3_avl_size       = cmd_size_q;
    assign rsp0_valid          = rsp0_valid_q;
    assign rsp1_valid          = rsp1_valid_q;
    assign rsp0_data           = rsp0_data_q;
    assign rsp1_data           = rsp1_data_q;
    assign outstanding         = cnt_q;
    assign err_flags           = err_q;

`ifdef DDR3_RD_ARB_STATS_EN
    logic [15:0] st0_q, st1_q;

    // Saturating per-requester acceptance counters
    always_ff @(posedge ddr3_clk) begin
        if (reset) begin
            st0_q <= '0;
            st1_q <= '0;
        end else begin
            if (req0_ack && (st0_q != 16'hFFFF)) st0_q <= st0_q + 16'd1;
            if (req1_ack && (st1_q != 16'hFFFF)) st1_q <= st1_q + 16'd1;
        end
    end

    assign stats = {st1_q, st0_q};
`else
    assign stats = 32'h0;
`endif

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Self-checking bench for ddr3_rd_arbiter: expected beats are queued when data is driven
// and compared when rsp0/rsp1 fire.
module tb_ddr3_rd_arbiter;
    localparam int unsigned STARVE = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ack, req1_ack;
    logic [25:0]  req0_addr, req1_addr;
    logic [2:0]   req0_size, req1_size;
    logic         rsp0_valid, rsp1_valid;
    logic [127:0] rsp0_data, rsp1_data;
    logic         ddr3_avl_ready, ddr3_avl_burstbegin, ddr3_avl_read_req;
    logic [2:0]   ddr3_avl_size;
    logic [25:0]  ddr3_avl_addr;
    logic         ddr3_avl_read_data_valid;
    logic [127:0] ddr3_avl_read_data;
    logic [4:0]   outstanding;
    logic [1:0]   err_flags;
    logic [31:0]  stats;

    always #5 clk = ~clk;

    ddr3_rd_arbiter #(.MAX_OUTSTANDING(16), .STARVE_LIMIT(STARVE), .MAX_BURST(4)) dut (
        .ddr3_clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size), .req0_ack(req0_ack),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size), .req1_ack(req1_ack),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
        .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_read_req(ddr3_avl_read_req),
        .ddr3_avl_addr(ddr3_avl_addr), .ddr3_avl_read_data_valid(ddr3_avl_read_data_valid),
        .ddr3_avl_read_data(ddr3_avl_read_data), .outstanding(outstanding),
        .err_flags(err_flags), .stats(stats)
    );

    typedef struct packed { logic id; logic [2:0] size; } cmd_t;
    typedef struct packed { logic id; logic [127:0] data; } rsp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t cmdq[$];
    rsp_t expq[$];
    logic ack_ids[$];
    int   beat_cnt = 0;

    function automatic logic [2:0] legal(input logic [2:0] s);
        return ((s == 3'd0) || (s > 3'd4)) ? 3'd1 : s;
    endfunction

    // Accepted-command record and response scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_ack) begin cmdq.push_back({1'b0, legal(req0_size)}); ack_ids.push_back(1'b0); end
            if (req1_ack) begin cmdq.push_back({1'b1, legal(req1_size)}); ack_ids.push_back(1'b1); end
            if (rsp0_valid || rsp1_valid) begin
                rsp_t e;
                n_checks++;
                if (rsp0_valid && rsp1_valid) begin
                    n_fail++; $display("FAIL rsp_both got=2 valids required=1");
                end else if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rsp_unexpected got rsp%0d valid required=none", rsp1_valid ? 1 : 0);
                end else begin
                    e = expq.pop_front();
                    if (rsp1_valid !== e.id || (e.id ? rsp1_data : rsp0_data) !== e.data) begin
                        n_fail++;
                        $display("FAIL rsp_route got id=%0d data=%h required id=%0d data=%h",
                                 rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
        req0_size = '0; req1_size = '0; ddr3_avl_ready = 1'b1;
        ddr3_avl_read_data_valid = 0; ddr3_avl_read_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmdq.delete(); expq.delete(); ack_ids.delete(); beat_cnt = 0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            ddr3_avl_read_data_valid = 1'b1; ddr3_avl_read_data = d;
            if (cmdq.size() > 0) begin
                expq.push_back({cmdq[0].id, d});
                beat_cnt++;
                if (beat_cnt == int'(cmdq[0].size)) begin void'(cmdq.pop_front()); beat_cnt = 0; end
            end
        end
        @(posedge clk); #1;
        ddr3_avl_read_data_valid = 1'b0;
    endtask

    task automatic req_cmd(input int who, input logic [25:0] a, input logic [2:0] s, input bit drop);
        int t;
        @(posedge clk); #1;
        if (who == 0) begin req0_valid = 1; req0_addr = a; req0_size = s; end
        else          begin req1_valid = 1; req1_addr = a; req1_size = s; end
        t = 0;
        do begin @(negedge clk); t++; end while (!((who == 0) ? req0_ack : req1_ack) && t < 200);
        if (t >= 200) begin
            n_checks++; n_fail++; $display("FAIL ack_timeout got no ack%0d required ack", who);
        end
        if (drop) begin
            @(posedge clk); #1;
            if (who == 0) req0_valid = 0; else req1_valid = 0;
        end
    endtask

    task automatic check_drained(input string tag);
        repeat (3) @(negedge clk);
        n_checks++;
        if (outstanding !== 5'd0 || expq.size() != 0) begin
            n_fail++; $display("FAIL %s_drain got outst=%0d pending=%0d required 0/0", tag, outstanding, expq.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({ddr3_avl_read_req, ddr3_avl_burstbegin, req0_ack, req1_ack, rsp0_valid, rsp1_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got nonzero control outputs required 0");
        end
        n_checks++;
        if (outstanding !== 5'd0 || err_flags !== 2'b00 || stats !== 32'h0) begin
            n_fail++; $display("FAIL reset_status got outst=%0d err=%b stats=%h required 0", outstanding, err_flags, stats);
        end
        n_checks++;
        if (ddr3_avl_addr !== 26'h0 || ddr3_avl_size !== 3'd0 || rsp0_data !== '0 || rsp1_data !== '0) begin
            n_fail++; $display("FAIL reset_data got addr=%h size=%0d required 0", ddr3_avl_addr, ddr3_avl_size);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 26'h000100; req0_size = 3'd4;
        @(negedge clk);
        n_checks++;
        if (ddr3_avl_read_req !== 1'b0) begin n_fail++; $display("FAIL single_early got read_req=1 required 0"); end
        @(negedge clk);
        n_checks++;
        if (ddr3_avl_read_req !== 1 || ddr3_avl_burstbegin !== 1 || req0_ack !== 1 || req1_ack !== 0 ||
            ddr3_avl_addr !== 26'h000100 || ddr3_avl_size !== 3'd4) begin
            n_fail++; $display("FAIL single_issue got rr=%b bb=%b ack0=%b addr=%h size=%0d required 1/1/1/000100/4",
                               ddr3_avl_read_req, ddr3_avl_burstbegin, req0_ack, ddr3_avl_addr, ddr3_avl_size);
        end
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding !== 5'd1 || ddr3_avl_read_req !== 0) begin
            n_fail++; $display("FAIL single_outst got outst=%0d rr=%b required 1/0", outstanding, ddr3_avl_read_req);
        end
        send_beats(4);
        check_drained("single");
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        ddr3_avl_ready = 0; req0_valid = 1; req0_addr = 26'h2ABCDE; req0_size = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ddr3_avl_read_req !== 1 || ddr3_avl_addr !== 26'h2ABCDE || ddr3_avl_size !== 3'd2 ||
                ddr3_avl_burstbegin !== (i == 0) || req0_ack !== 0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got rr=%b bb=%b ack=%b addr=%h size=%0d required 1/%0d/0/2abcde/2",
                                   i, ddr3_avl_read_req, ddr3_avl_burstbegin, req0_ack, ddr3_avl_addr, ddr3_avl_size, i == 0);
            end
        end
        @(posedge clk); #1 ddr3_avl_ready = 1;
        @(negedge clk);
        n_checks++;
        if (req0_ack !== 1 || ddr3_avl_read_req !== 1 || ddr3_avl_burstbegin !== 0) begin
            n_fail++; $display("FAIL bp_accept got ack=%b rr=%b bb=%b required 1/1/0", req0_ack, ddr3_avl_read_req, ddr3_avl_burstbegin);
        end
        @(posedge clk); #1 req0_valid = 0;
        send_beats(2);
        check_drained("bp");
    endtask

    task automatic test_contention();
        logic [9:0] exp_order;
        exp_order = 10'b10_0001_0000;
        ack_ids.delete();
        fork
            begin for (int i = 0; i < 8; i++) req_cmd(0, 26'(32'h1000 + i * 16), 3'((i % 4) + 1), i == 7); end
            begin for (int j = 0; j < 2; j++) req_cmd(1, 26'(32'h2000 + j * 16), 3'd2, j == 1); end
        join
        n_checks++;
        if (ack_ids.size() != 10) begin
            n_fail++; $display("FAIL cont_count got %0d acks required 10", ack_ids.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (ack_ids[k] !== exp_order[k]) begin
                    n_fail++; $display("FAIL cont_order[%0d] got req%0d required req%0d", k, ack_ids[k], exp_order[k]);
                end
            end
        end
        send_beats(24);
        check_drained("cont");
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) req_cmd(0, 26'(32'h3000 + i), 3'd1, i == 15);
        @(negedge clk);
        n_checks++;
        if (outstanding !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d required 16", outstanding); end
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 26'h3FFFF0; req0_size = 3'd1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin @(negedge clk); if (req0_ack || ddr3_avl_read_req) seen++; end
            n_checks++;
            if (seen != 0) begin n_fail++; $display("FAIL full_block got %0d issue cycles required 0", seen); end
        end
        send_beats(1);
        @(negedge clk);
        n_checks++;
        if (outstanding !== 5'd15 || req0_ack !== 0) begin
            n_fail++; $display("FAIL full_pop got outst=%0d ack=%b required 15/0", outstanding, req0_ack);
        end
        @(negedge clk);
        n_checks++;
        if (req0_ack !== 1 || ddr3_avl_addr !== 26'h3FFFF0) begin
            n_fail++; $display("FAIL full_resume got ack=%b addr=%h required 1/3ffff0", req0_ack, ddr3_avl_addr);
        end
        @(posedge clk); #1 req0_valid = 0;
        send_beats(16);
        check_drained("full");
    endtask

    task automatic test_errors();
        send_beats(1);
        @(negedge clk);
        n_checks++;
        if (err_flags !== 2'b01) begin n_fail++; $display("FAIL orphan_flag got %b required 01", err_flags); end
        @(posedge clk); #1;
        req1_valid = 1; req1_addr = 26'h0000AA; req1_size = 3'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ddr3_avl_read_req !== 1 || ddr3_avl_size !== 3'd1 || req1_ack !== 1 || err_flags !== 2'b11) begin
            n_fail++; $display("FAIL size0 got rr=%b size=%0d ack1=%b err=%b required 1/1/1/11",
                               ddr3_avl_read_req, ddr3_avl_size, req1_ack, err_flags);
        end
        @(posedge clk); #1 req1_valid = 0;
        send_beats(1);
        check_drained("err");
    endtask

    task automatic test_reset_midburst();
        req_cmd(0, 26'h000444, 3'd4, 1'b1);
        send_beats(2);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        n_checks++;
        if (outstanding !== 5'd0 || err_flags !== 2'b00) begin
            n_fail++; $display("FAIL midrst_clear got outst=%0d err=%b required 0/00", outstanding, err_flags);
        end
        send_beats(1);
        @(negedge clk);
        n_checks++;
        if (err_flags !== 2'b01) begin n_fail++; $display("FAIL midrst_orphan got %b required 01", err_flags); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_stats;
        do_reset();
        for (int i = 0; i < 3; i++) req_cmd(0, 26'(32'h5000 + i), 3'd1, 1'b1);
        for (int i = 0; i < 2; i++) req_cmd(1, 26'(32'h6000 + i), 3'd1, 1'b1);
`ifdef DDR3_RD_ARB_STATS_EN
        exp_stats = 32'h0002_0003;
`else
        exp_stats = 32'h0;
`endif
        @(negedge clk);
        n_checks++;
        if (stats !== exp_stats) begin n_fail++; $display("FAIL stats got %h required %h", stats, exp_stats); end
        send_beats(5);
        check_drained("stats");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_full();
        test_errors();
        test_reset_midburst();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr3_rd_arbiter.md
Name: ddr3_rd_arbiter

Overview:
- Shares the single DDR3 Avalon-MM read port between two requesters.
  - Requester 0: VGA frame-fetch prefetcher, high priority.
  - Requester 1: secondary reader, e.g. CSR readback or overlay fetch.
- Issues bursts, tracks outstanding reads in an in-order tag FIFO, and steers each returned 128-bit beat to the requester that issued it.
- Sits in the ddr3_clk domain between the requesters and the memory controller's Avalon port.

Parameters:
- MAX_OUTSTANDING, 16: tag FIFO depth (power of 2); maximum accepted commands still awaiting data.
- STARVE_LIMIT, 64: cycles requester 1 may wait with valid high before it takes priority over requester 0.
- MAX_BURST, 4: largest legal ddr3_avl_size value.

Ports:
- ddr3_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command pending; held with addr/size until req0_ack.
- req0_addr  in  26  requester 0 word address.
- req0_size  in  3  requester 0 burst length in beats.
- req0_ack  out  1  one-cycle pulse: requester 0 command accepted by DDR.
- rsp0_valid  out  1  beat for requester 0.
- rsp0_data  out  128  beat data for requester 0.
- req1_valid, req1_addr, req1_size, req1_ack, rsp1_valid, rsp1_data: same widths and meaning for requester 1.
- ddr3_avl_ready  in  1  controller accepts command.
- ddr3_avl_burstbegin  out  1  first-presentation cycle of a command.
- ddr3_avl_size  out  3  burst beats.
- ddr3_avl_read_req  out  1  read command valid.
- ddr3_avl_addr  out  26  command address.
- ddr3_avl_read_data_valid  in  1  returned beat valid.
- ddr3_avl_read_data  in  128  returned beat.
- outstanding  out  5  commands accepted, not fully returned (0..MAX_OUTSTANDING).
- err_flags  out  2  sticky errors: [0] orphan beat, [1] illegal size.
- stats  out  32  grant statistics (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) clears all state. All outputs are 0; state is IDLE.
- FSM states: IDLE, ISSUE.
- IDLE transition:
  - Condition: (req0_valid | req1_valid) and outstanding < MAX_OUTSTANDING.
  - Grant requester 0, unless the starvation rule applies, in which case grant requester 1.
  - Latch the granted addr/size into command registers; go to ISSUE next cycle.
- Starvation counter:
  - Increments each cycle req1_valid=1 and requester 1 is not granted, saturating at STARVE_LIMIT.
  - Clears on req1_ack or when req1_valid=0.
  - When the counter equals STARVE_LIMIT, requester 1 wins the next IDLE arbitration.
- ISSUE:
  - ddr3_avl_read_req=1; addr and size driven from the registers and stable.
  - ddr3_avl_burstbegin=1 only in the first ISSUE cycle.
- Acceptance: the cycle with read_req & ddr3_avl_ready. In that cycle:
  - Push {id, size} to the tag FIFO.
  - Pulse reqN_ack for the granted requester.
  - Return to IDLE.
- Throughput: at best one command per 2 cycles; no back-to-back issue.
- Command latency: from valid seen in IDLE to read_req is 1 cycle.
- Illegal size: size 0 or size > MAX_BURST is issued as size 1 and sets err_flags[1].
- Return path:
  - Each ddr3_avl_read_data_valid beat goes to the FIFO head entry's requester.
  - rspN_valid and rspN_data are registered: 1 cycle after read_data_valid.
  - The other rsp valid stays 0.
  - A beat counter counts beats for the head entry; on the beat where count == head size, pop the entry and clear the counter.
- Orphan beat: read_data_valid with the tag FIFO empty → beat dropped, err_flags[0] set, no rsp valid.
- outstanding: +1 on push, -1 on pop, unchanged when push and pop occur in the same cycle.
- Full: at outstanding == MAX_OUTSTANDING, stay in IDLE. Requesters see no ack. A pop in that cycle allows a grant next cycle.
- Requester rules:
  - A requester must not drop valid before its ack.
  - Changes to a non-granted requester's inputs are ignored.
- Reset mid-burst: the command is abandoned and the FIFO cleared. Beats arriving afterwards raise the orphan flag. This block must be reset together with the memory interface.

Optional Feature:
- Macro: DDR3_RD_ARB_STATS_EN.
- Defined:
  - stats[15:0] counts req0 acks; stats[31:16] counts req1 acks.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: stats is tied to 32'h0 and no counter logic is built.

Test Plan:
- Single request: req0 addr=26'h000100, size=4, ready=1 → read_req and burstbegin in cycle +1, req0_ack the same cycle. 4 data beats → 4 rsp0_valid pulses with matching data; outstanding returns 1→0.
- Contention: req0 and req1 valid continuously, STARVE_LIMIT=8 → req0 granted repeatedly; req1 granted once its counter reaches 8; order verified through tag routing.
- Backpressure: ready=0 for 5 cycles → read_req, addr and size held stable; burstbegin high only in the first cycle; ack on the cycle ready=1.
- Full: ready=1, no data returned, 16 commands → outstanding=16 and no further acks. One burst returns → grant resumes the next cycle.
- Errors: read_data_valid with empty FIFO → err_flags=2'b01, no rsp valid. req1 size=0 → issued as size 1, err_flags[1]=1.
- Stats: with DDR3_RD_ARB_STATS_EN, 3 req0 and 2 req1 commands → stats=32'h0002_0003. Without the macro → stats=0.
